mealy_framer_tx: RTL and testbench

- Serial frame transmitter; the sending end of the "three consecutive zeros" Mealy sequence detector.
- Accepts a parallel word over a valid/ready handshake and emits one bit per clock on `out`.
- Each frame starts with the 3-zero sync marker. Payload zeros are bit-stuffed so a downstream 000-detector fires exactly once per frame, on the marker.
- Sits between the parallel data source and the serial line feeding the detector.

---
 rtl/framer_pkg.sv | 19 +
 rtl/framer_zero_run.sv | 28 ++
 rtl/mealy_framer_tx.sv | 166 ++++++++++++++++
 tb/tb_mealy_framer_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared types and constants for the serial frame transmitter.
// No ports; imported by framer_zero_run and mealy_framer_tx.
package framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEP,
        DATA,
        STUFF,
        PARITY,
        GUARD
    } state_t;

    localparam int   SYNC_LEN  = 3;
    localparam int   STUFF_RUN = 2;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/framer_zero_run.sv
// Zero-run tracker for emitted payload/parity bits.
// Ports: clock, reset (sync, active-high), zero (a payload 0 is
// being put on the line this edge), stuff_req (run reached limit).
module framer_zero_run
    import framer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic zero,
    output logic stuff_req
);

    logic [1:0] run;

    // Anything other than a payload zero breaks the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            run <= '0;
        end else if (zero) begin
            run <= run + 2'd1;
        end else begin
            run <= '0;
        end
    end

    assign stuff_req = (run == 2'(STUFF_RUN));

endmodule

// File: rtl/mealy_framer_tx.sv
// Serial frame transmitter: sync 000, separator, bit-stuffed payload.
// Ports: clock, reset (sync, active-high), data_in/data_valid/
// data_ready (word handshake), out (serial line, idle 1),
// frame_start (pulse on first sync bit), busy (frame in flight).
// Optional: define FRAMER_PARITY_EN to append a stuffed even-parity bit.
module mealy_framer_tx
    import framer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out,
    output logic              frame_start,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bitcnt;
    logic [1:0]        synccnt;
    logic              stuff_req;
    logic              zero_emit;
    logic              last;
    logic              go_data;
    logic              go_stuff;
`ifdef FRAMER_PARITY_EN
    logic              go_par;
    logic              par_q;
    logic              par_done;
`endif

    assign last       = (bitcnt == BW'(DATA_W));
    assign busy       = (state != IDLE);
    assign data_ready = (state == IDLE) && !reset;

    // Decide what the next emitted symbol is once past the marker.
    always_comb begin
        go_data  = 1'b0;
        go_stuff = 1'b0;
`ifdef FRAMER_PARITY_EN
        go_par   = 1'b0;
`endif
        unique case (state)
            SEP: go_data = 1'b1;
            DATA: begin
                if (stuff_req) begin
                    go_stuff = 1'b1;
                end else if (!last) begin
                    go_data = 1'b1;
                end
`ifdef FRAMER_PARITY_EN
                else begin
                    go_par = 1'b1;
                end
`endif
            end
            STUFF: begin
`ifdef FRAMER_PARITY_EN
                if (!last) begin
                    go_data = 1'b1;
                end else if (!par_done) begin
                    go_par = 1'b1;
                end
`else
                go_data = !last;
`endif
            end
            PARITY: go_stuff = stuff_req;
            default: ;
        endcase
    end

`ifdef FRAMER_PARITY_EN
    assign zero_emit = (go_data && !shreg[DATA_W-1])
                     || (go_par && !par_q);
`else
    assign zero_emit = go_data && !shreg[DATA_W-1];
`endif

    framer_zero_run u_zero_run (
        .clock     (clock),
        .reset     (reset),
        .zero      (zero_emit),
        .stuff_req (stuff_req)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            out         <= LINE_IDLE;
            frame_start <= 1'b0;
            shreg       <= '0;
            bitcnt      <= '0;
            synccnt     <= '0;
`ifdef FRAMER_PARITY_EN
            par_q       <= 1'b0;
            par_done    <= 1'b0;
`endif
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    out <= LINE_IDLE;
                    if (data_valid) begin
                        state       <= SYNC;
                        out         <= 1'b0;
                        frame_start <= 1'b1;
                        shreg       <= data_in;
                        bitcnt      <= '0;
                        synccnt     <= '0;
`ifdef FRAMER_PARITY_EN
                        par_q       <= ^data_in;
                        par_done    <= 1'b0;
`endif
                    end
                end
                SYNC: begin
                    if (synccnt == 2'(SYNC_LEN - 1)) begin
                        state <= SEP;
                        out   <= 1'b1;
                    end else begin
                        synccnt <= synccnt + 2'd1;
                        out     <= 1'b0;
                    end
                end
                SEP, DATA, STUFF, PARITY: begin
                    if (go_data) begin
                        state  <= DATA;
                        out    <= shreg[DATA_W-1];
                        shreg  <= {shreg[DATA_W-2:0], 1'b0};
                        bitcnt <= bitcnt + BW'(1);
                    end
`ifdef FRAMER_PARITY_EN
                    else if (go_par) begin
                        state    <= PARITY;
                        out      <= par_q;
                        par_done <= 1'b1;
                    end
`endif
                    else if (go_stuff) begin
                        state <= STUFF;
                        out   <= 1'b1;
                    end else begin
                        state <= GUARD;
                        out   <= 1'b1;
                    end
                end
                GUARD: begin
                    state <= IDLE;
                    out   <= LINE_IDLE;
                end
                default: begin
                    state <= IDLE;
                    out   <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_framer_tx.sv
// Bench for mealy_framer_tx: frame-level reference model and
// a 000-detector on the line, checked every cycle.
module tb_mealy_framer_tx;

    localparam int DW = 8;

    typedef bit bq_t[$];

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic          out;
    logic          frame_start;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int det_cnt = 0;

    mealy_framer_tx #(.DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .out         (out),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Whole frame as a bit list: marker, separator, stuffed
    // payload (and parity), guard.
    function automatic bq_t frame_bits(input logic [DW-1:0] w);
        bq_t f;
        int  run;
        bit  b;
        f = '{0, 0, 0, 1};
        run = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            b = w[i];
            f.push_back(b);
            run = b ? 0 : run + 1;
            if (run == 2) begin
                f.push_back(1);
                run = 0;
            end
        end
`ifdef FRAMER_PARITY_EN
        b = ^w;
        f.push_back(b);
        run = b ? 0 : run + 1;
        if (run == 2) f.push_back(1);
`endif
        f.push_back(1);
        return f;
    endfunction

    // Reference model and per-cycle compare.
    bq_t      q;
    bit       mbusy = 0;
    bit       mfs = 0;
    bit       mout = 1;
    int       midx = -1;
    logic [2:0] hist = 3'b111;

    always @(posedge clock) begin
        logic          r;
        logic          v;
        logic [DW-1:0] d;
        logic          det;
        r = reset;
        v = data_valid;
        d = data_in;
        if (r) begin
            q.delete();
            mbusy = 0;
            mout  = 1;
            mfs   = 0;
            midx  = -1;
        end else begin
            mfs = 0;
            if (q.size() == 0 && !mbusy && v) begin
                q    = frame_bits(d);
                mfs  = 1;
                midx = -1;
            end
            if (q.size() != 0) begin
                mout  = q.pop_front();
                mbusy = 1;
                midx++;
            end else begin
                mout  = 1;
                mbusy = 0;
                midx  = -1;
            end
        end
        #1;
        hist = r ? 3'b111 : {hist[1:0], out};
        det  = (hist == 3'b000);
        if (det) det_cnt++;
        chk("out", 32'(out), 32'(mout));
        chk("frame_start", 32'(frame_start), 32'(mfs));
        chk("busy", 32'(busy), 32'(mbusy));
        chk("data_ready", 32'(data_ready),
            32'(!mbusy && !reset));
        chk("detector", 32'(det), 32'(mbusy && midx == 2));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [DW-1:0] w);
        int n;
        n = 0;
        @(negedge clock);
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("send_accept", 32'(n < 60), 32'd1);
        @(negedge clock);
        data_valid = 1'b0;
        data_in    = DW'($urandom);
    endtask

    initial begin : main
        bq_t           f;
        logic [31:0]   v;
        logic [DW-1:0] words [3];
        int            c0;
        int            n;

        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        words      = '{8'h00, 8'h5A, 8'hFF};

`ifdef FRAMER_PARITY_EN
        f = frame_bits(8'h01);
        chk("pin_len_01", 32'(f.size()), 32'd17);
        chk("pin_par_01", 32'(f[15]), 32'd1);
        f = frame_bits(8'hFF);
        chk("pin_len_ff", 32'(f.size()), 32'd14);
`else
        f = frame_bits(8'hFF);
        chk("pin_len_ff", 32'(f.size()), 32'd13);
        f = frame_bits(8'h00);
        chk("pin_len_00", 32'(f.size()), 32'd17);
        f = frame_bits(8'hA5);
        chk("pin_len_a5", 32'(f.size()), 32'd14);
        v = '0;
        foreach (f[i]) v = {v[30:0], f[i]};
        chk("pin_seq_a5", v, 32'b00011010011011);
`endif

        idle(3);
        reset = 1'b0;

        send(8'hFF); idle(16);
        send(8'h00); idle(20);
        send(8'hA5); idle(18);
`ifdef FRAMER_PARITY_EN
        send(8'h01); idle(20);
`endif

        send(8'h5A); idle(6);
        reset = 1'b1; idle(3);
        reset = 1'b0; idle(4);

        c0 = det_cnt;
        data_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = words[k];
            n = 0;
            while (!data_ready && n < 60) begin
                @(negedge clock);
                n++;
            end
            chk("b2b_accept", 32'(n < 60), 32'd1);
            @(negedge clock);
        end
        data_valid = 1'b0;
        idle(24);
        chk("b2b_det_pulses", 32'(det_cnt - c0), 32'd3);

        send(8'h00); idle(8);
        reset = 1'b1; idle(1);
        reset = 1'b0; idle(2);
        send(8'hFF); idle(16);

        for (int i = 0; i < 1200; i++) begin
            @(negedge clock);
            data_in    = DW'($urandom);
            data_valid = ($urandom_range(2) != 0);
            reset      = ($urandom_range(96) == 0);
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        idle(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
